pipe_hazard_ctrl: RTL

Central sequencer for the 5-stage MIPS pipeline registers (IF/ID, ID/EX, EX/ME, ME/WB).
- Detects load-use hazards, taken branches and data-memory wait states.
- Drives per-register enable/flush and the PC enable.
- Generates EX-stage operand forwarding selects.
- Owns a small FSM so stalls and memory waits are sequenced deterministically; pipeline registers only obey en/flush.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/fwd_unit.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and EX-stage forwarding select values.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun       = 2'd0,
        StLoadStall = 2'd1,
        StMemWait   = 2'd2
    } state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_ME  = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // True when a producer writing register rd can supply source register src.
    function automatic logic rd_matches(input logic regwr, input logic [4:0] rd,
                                        input logic [4:0] src);
        return regwr && (rd != 5'd0) && (rd == src);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// Forwarding select for one EX-stage source operand. ME wins over WB;
// register $0 is never forwarded.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] me_rd_i,
    input  logic       me_regwr_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwr_i,
    output logic [1:0] sel_o
);

    // Priority select: youngest producer first.
    always_comb begin
        sel_o = FWD_REG;
        if (rd_matches(me_regwr_i, me_rd_i, src_i)) begin
            sel_o = FWD_ME;
        end else if (rd_matches(wb_regwr_i, wb_rd_i, src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard sequencer for the 5-stage pipeline registers.
// Optional performance counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_mem2reg_i,
    input  logic       ex_regwr_i,
    input  logic [4:0] ex_rs_i,
    input  logic [4:0] ex_rt_i,
    input  logic [4:0] me_rd_i,
    input  logic       me_regwr_i,
    input  logic [4:0] wb_rd_i,
    input  logic       wb_regwr_i,
    input  logic       ex_branch_taken_i,
    input  logic       mem_req_i,
    input  logic       mem_ready_i,
    output logic       pc_en_o,
    output logic       if_id_en_o,
    output logic       if_id_flush_o,
    output logic       id_ex_en_o,
    output logic       id_ex_flush_o,
    output logic       ex_me_en_o,
    output logic       me_wb_flush_o,
    output logic [1:0] fwd_a_o,
    output logic [1:0] fwd_b_o,
    output logic       mem_err_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_events_o,
    output logic [CNT_W-1:0] mem_wait_cycles_o
`endif
);

    // Counter only needs to reach MEM_TIMEOUT; it saturates there.
    localparam int unsigned TmoW = $clog2(MEM_TIMEOUT + 2);
    localparam logic [TmoW-1:0] TmoVal = TmoW'(MEM_TIMEOUT);
    localparam bit TmoEn = (MEM_TIMEOUT != 0);

    state_e          state_q, state_d;
    logic [TmoW-1:0] wait_cnt_q, wait_cnt_d;
    logic            mem_err_q, mem_err_d;

    logic       mem_wait;
    logic       load_use;
    logic       stall_evt;
    logic       flush_evt;
    logic [1:0] sel_a, sel_b;

    assign mem_wait = mem_req_i & ~mem_ready_i;
    assign load_use = ex_mem2reg_i
                    & rd_matches(ex_regwr_i, ex_rd_i, id_rs_i)
                    | ex_mem2reg_i & id_uses_rt_i
                    & rd_matches(ex_regwr_i, ex_rd_i, id_rt_i);

    fwd_unit u_fwd_a (
        .src_i      (ex_rs_i),
        .me_rd_i    (me_rd_i),
        .me_regwr_i (me_regwr_i),
        .wb_rd_i    (wb_rd_i),
        .wb_regwr_i (wb_regwr_i),
        .sel_o      (sel_a)
    );

    fwd_unit u_fwd_b (
        .src_i      (ex_rt_i),
        .me_rd_i    (me_rd_i),
        .me_regwr_i (me_regwr_i),
        .wb_rd_i    (wb_rd_i),
        .wb_regwr_i (wb_regwr_i),
        .sel_o      (sel_b)
    );

    // Next state and pipeline controls; priority is mem wait > branch > load-use.
    always_comb begin
        state_d       = StRun;
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_en_o    = 1'b1;
        id_ex_flush_o = 1'b0;
        ex_me_en_o    = 1'b1;
        me_wb_flush_o = 1'b0;
        fwd_a_o       = sel_a;
        fwd_b_o       = sel_b;
        stall_evt     = 1'b0;
        flush_evt     = 1'b0;

        if (mem_wait) begin
            state_d       = StMemWait;
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_en_o    = 1'b0;
            ex_me_en_o    = 1'b0;
            me_wb_flush_o = 1'b1;
        end else if (ex_branch_taken_i) begin
            // ID instruction is discarded, so any load-use on it is moot.
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
            flush_evt     = 1'b1;
        end else if (load_use && (state_q != StLoadStall)) begin
            // One bubble is enough; LOAD_STALL masks the still-visible hazard.
            state_d       = StLoadStall;
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            stall_evt     = 1'b1;
        end

        if (!rst_ni) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            ex_me_en_o    = 1'b0;
            me_wb_flush_o = 1'b1;
            fwd_a_o       = FWD_REG;
            fwd_b_o       = FWD_REG;
        end
    end

    // Wait-cycle counter and sticky timeout flag.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (mem_wait) begin
            wait_cnt_d = wait_cnt_q;
            if (TmoEn && (wait_cnt_q != TmoVal)) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (TmoEn && (wait_cnt_d == TmoVal)) begin
                mem_err_d = 1'b1;
            end
        end
    end

    // State, wait counter and error flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StRun;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
        end
    end

    assign mem_err_o = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, flush_events_q, mem_wait_cycles_q;

    // Free-running event counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q    <= '0;
            flush_events_q    <= '0;
            mem_wait_cycles_q <= '0;
        end else begin
            stall_cycles_q    <= stall_cycles_q + CNT_W'(stall_evt);
            flush_events_q    <= flush_events_q + CNT_W'(flush_evt);
            mem_wait_cycles_q <= mem_wait_cycles_q + CNT_W'(mem_wait);
        end
    end

    assign stall_cycles_o    = stall_cycles_q;
    assign flush_events_o    = flush_events_q;
    assign mem_wait_cycles_o = mem_wait_cycles_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    logic             unused_evt;
    assign unused_cnt_w = '0;
    assign unused_evt   = stall_evt ^ flush_evt;
`endif

endmodule
